// File: rtl/dual_issue_hazard_ctrl_pkg.sv
// Shared types for the dual-issue hazard controller: register address width,
// the per-stage destination tag and the issue FSM states.
package dual_issue_hazard_ctrl_pkg;

    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    // Destination tag carried by every pipeline stage for each lane
    typedef struct packed {
        logic              valid;
        logic              we;
        logic              load;
        logic [REG_AW-1:0] rd;
    } stage_tag_t;

    // Source operand fields captured into EX for the bypass network
    typedef struct packed {
        logic              r1;
        logic              r2;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } src_t;

    typedef enum logic {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } issue_state_t;

    // A tag only produces a forwardable value when it really writes a non-zero register
    function automatic logic tag_writes(input stage_tag_t t);
        return t.valid & t.we & (t.rd != '0);
    endfunction

endpackage

// File: rtl/dual_issue_hazard_ctrl_hazard_match.sv
// Load-use detector for one decode lane: flags when any EX lane holds a load
// whose destination is one of the sources this lane actually reads.
module hazard_match
    import dual_issue_hazard_ctrl_pkg::*;
(
    input  logic             id_valid,
    input  src_t             src,
    input  stage_tag_t [1:0] tags,
    output logic             load_use
);

    // Scan both EX tags; an invalid decode lane can never request a stall
    always_comb begin
        load_use = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (id_valid && tags[j].load && tag_writes(tags[j]) &&
                ((src.r1 && (src.rs1 == tags[j].rd)) ||
                 (src.r2 && (src.rs2 == tags[j].rd)))) begin
                load_use = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_issue_hazard_ctrl.sv
// Pipeline control for the dual-issue ID->EX->LSU->WB pipeline: tracks the
// destination tags of both lanes, serialises dependent pairs, stalls on
// load-use and feeds the EX-stage operand bypass network.
module dual_issue_hazard_ctrl
    import dual_issue_hazard_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              id_valid_0_i,
    input  logic              id_we_0_i,
    input  logic [REG_AW-1:0] id_rd_0_i,
    input  logic              id_load_0_i,
    input  logic              id_r1_0_i,
    input  logic              id_r2_0_i,
    input  logic [REG_AW-1:0] id_rs1_0_i,
    input  logic [REG_AW-1:0] id_rs2_0_i,
    input  logic              id_valid_1_i,
    input  logic              id_we_1_i,
    input  logic [REG_AW-1:0] id_rd_1_i,
    input  logic              id_load_1_i,
    input  logic              id_r1_1_i,
    input  logic              id_r2_1_i,
    input  logic [REG_AW-1:0] id_rs1_1_i,
    input  logic [REG_AW-1:0] id_rs2_1_i,
    input  logic              mem_stall_i,
    input  logic              flush_i,
    output logic              stall_id_o,
    output logic              ex_valid_0_o,
    output logic              ex_valid_1_o,
    output logic              r0_1_o,
    output logic              r0_2_o,
    output logic              r1_1_o,
    output logic              r1_2_o,
    output logic [REG_AW-1:0] a0_1_o,
    output logic [REG_AW-1:0] a0_2_o,
    output logic [REG_AW-1:0] a1_1_o,
    output logic [REG_AW-1:0] a1_2_o,
    output logic              wm0_o,
    output logic              wm1_o,
    output logic [REG_AW-1:0] am0_o,
    output logic [REG_AW-1:0] am1_o,
    output logic              ww0_o,
    output logic              ww1_o,
    output logic [REG_AW-1:0] aw0_o,
    output logic [REG_AW-1:0] aw1_o
);

    stage_tag_t [1:0] id_tag;
    src_t       [1:0] id_src;
    stage_tag_t [1:0] ex_tag;
    src_t       [1:0] ex_src;
    stage_tag_t [1:0] lsu_tag;
    stage_tag_t [1:0] wb_tag;

    issue_state_t state;
    issue_state_t state_next;

    logic pair_hazard;
    logic load_use0;
    logic load_use1;
    logic issue0;
    logic issue1;
    logic stall_req;
    logic unused_wb_load;

    assign id_tag[0] = {id_valid_0_i, id_we_0_i, id_load_0_i, id_rd_0_i};
    assign id_tag[1] = {id_valid_1_i, id_we_1_i, id_load_1_i, id_rd_1_i};
    assign id_src[0] = {id_r1_0_i, id_r2_0_i, id_rs1_0_i, id_rs2_0_i};
    assign id_src[1] = {id_r1_1_i, id_r2_1_i, id_rs1_1_i, id_rs2_1_i};

    // Lane1 depends on lane0 (RAW) or both write the same register (WAW)
    assign pair_hazard = id_valid_0_i & id_valid_1_i & id_we_0_i & (id_rd_0_i != '0) &
                         ((id_r1_1_i & (id_rs1_1_i == id_rd_0_i)) |
                          (id_r2_1_i & (id_rs2_1_i == id_rd_0_i)) |
                          (id_we_1_i & (id_rd_1_i == id_rd_0_i)));

    hazard_match u_match0 (
        .id_valid (id_valid_0_i),
        .src      (id_src[0]),
        .tags     (ex_tag),
        .load_use (load_use0)
    );

    hazard_match u_match1 (
        .id_valid (id_valid_1_i),
        .src      (id_src[1]),
        .tags     (ex_tag),
        .load_use (load_use1)
    );

    // Issue decision: memory stall freezes everything, flush redirects, otherwise PAIR/SECOND rules
    always_comb begin
        state_next = state;
        issue0     = 1'b0;
        issue1     = 1'b0;
        stall_req  = 1'b0;
        if (mem_stall_i) begin
            stall_req = 1'b1;
        end else if (flush_i) begin
            state_next = PAIR;
        end else begin
            case (state)
                PAIR: begin
                    if (load_use0 || (load_use1 && !pair_hazard)) begin
                        stall_req = 1'b1;
                    end else if (pair_hazard) begin
                        issue0     = 1'b1;
                        stall_req  = 1'b1;
                        state_next = SECOND;
                    end else begin
                        issue0 = 1'b1;
                        issue1 = 1'b1;
                    end
                end
                SECOND: begin
                    if (load_use1) begin
                        stall_req = 1'b1;
                    end else begin
                        issue1     = 1'b1;
                        state_next = PAIR;
                    end
                end
                default: state_next = PAIR;
            endcase
        end
    end

    // FSM state register; holds by itself during a memory stall
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= PAIR;
        end else begin
            state <= state_next;
        end
    end

    // EX stage: capture issued lanes, everything else becomes an all-zero bubble
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ex_tag <= '0;
            ex_src <= '0;
        end else if (!mem_stall_i) begin
            ex_tag[0] <= (issue0 && id_valid_0_i) ? id_tag[0] : '0;
            ex_src[0] <= (issue0 && id_valid_0_i) ? id_src[0] : '0;
            ex_tag[1] <= (issue1 && id_valid_1_i) ? id_tag[1] : '0;
            ex_src[1] <= (issue1 && id_valid_1_i) ? id_src[1] : '0;
        end
    end

    // LSU and WB tags shift down every unstalled cycle, including flush cycles
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lsu_tag <= '0;
            wb_tag  <= '0;
        end else if (!mem_stall_i) begin
            lsu_tag <= ex_tag;
            wb_tag  <= lsu_tag;
        end
    end

    assign stall_id_o   = stall_req & rstn_i;
    assign ex_valid_0_o = ex_tag[0].valid;
    assign ex_valid_1_o = ex_tag[1].valid;
    assign r0_1_o       = ex_src[0].r1;
    assign r0_2_o       = ex_src[0].r2;
    assign r1_1_o       = ex_src[1].r1;
    assign r1_2_o       = ex_src[1].r2;
    assign a0_1_o       = ex_src[0].rs1;
    assign a0_2_o       = ex_src[0].rs2;
    assign a1_1_o       = ex_src[1].rs1;
    assign a1_2_o       = ex_src[1].rs2;
    assign wm0_o        = lsu_tag[0].valid & lsu_tag[0].we;
    assign wm1_o        = lsu_tag[1].valid & lsu_tag[1].we;
    assign am0_o        = lsu_tag[0].rd;
    assign am1_o        = lsu_tag[1].rd;
    assign aw0_o        = wb_tag[0].rd;
    assign aw1_o        = wb_tag[1].rd;
    assign ww1_o        = wb_tag[1].valid & wb_tag[1].we;
    // The fixed bypass order would let older wb0 beat younger lsu1; suppress wb0 then
    assign ww0_o        = wb_tag[0].valid & wb_tag[0].we & ~(wm1_o & (am1_o == aw0_o));

    assign unused_wb_load = wb_tag[0].load ^ wb_tag[1].load;

endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// Self-checking bench for dual_issue_hazard_ctrl: directed scenarios plus a
// randomized run, all compared against a behavioural pipeline model.
module tb_dual_issue_hazard_ctrl;

    typedef struct {
        bit v;
        bit we;
        bit ld;
        int rd;
        bit r1;
        bit r2;
        int rs1;
        int rs2;
    } rec_t;

    logic       clk;
    logic       rstn;
    logic       id_valid_0, id_we_0, id_load_0, id_r1_0, id_r2_0;
    logic [4:0] id_rd_0, id_rs1_0, id_rs2_0;
    logic       id_valid_1, id_we_1, id_load_1, id_r1_1, id_r2_1;
    logic [4:0] id_rd_1, id_rs1_1, id_rs2_1;
    logic       mem_stall, flush;
    logic       stall_id, ex_valid_0, ex_valid_1;
    logic       r0_1, r0_2, r1_1, r1_2;
    logic [4:0] a0_1, a0_2, a1_1, a1_2;
    logic       wm0, wm1, ww0, ww1;
    logic [4:0] am0, am1, aw0, aw1;
    logic [49:0] act;

    rec_t m_ex[2], m_lsu[2], m_wb[2], n_ex[2], cur[2];
    bit   m_second, n_second, cur_ms, cur_fl;
    bit   exp_stall;
    logic [49:0] exp_outs;
    int   n_tests = 0;
    int   n_fail  = 0;

    dual_issue_hazard_ctrl dut (
        .clk_i(clk), .rstn_i(rstn),
        .id_valid_0_i(id_valid_0), .id_we_0_i(id_we_0), .id_rd_0_i(id_rd_0), .id_load_0_i(id_load_0),
        .id_r1_0_i(id_r1_0), .id_r2_0_i(id_r2_0), .id_rs1_0_i(id_rs1_0), .id_rs2_0_i(id_rs2_0),
        .id_valid_1_i(id_valid_1), .id_we_1_i(id_we_1), .id_rd_1_i(id_rd_1), .id_load_1_i(id_load_1),
        .id_r1_1_i(id_r1_1), .id_r2_1_i(id_r2_1), .id_rs1_1_i(id_rs1_1), .id_rs2_1_i(id_rs2_1),
        .mem_stall_i(mem_stall), .flush_i(flush), .stall_id_o(stall_id),
        .ex_valid_0_o(ex_valid_0), .ex_valid_1_o(ex_valid_1),
        .r0_1_o(r0_1), .r0_2_o(r0_2), .r1_1_o(r1_1), .r1_2_o(r1_2),
        .a0_1_o(a0_1), .a0_2_o(a0_2), .a1_1_o(a1_1), .a1_2_o(a1_2),
        .wm0_o(wm0), .wm1_o(wm1), .am0_o(am0), .am1_o(am1),
        .ww0_o(ww0), .ww1_o(ww1), .aw0_o(aw0), .aw1_o(aw1)
    );

    assign act = {ex_valid_0, ex_valid_1, r0_1, r0_2, r1_1, r1_2, a0_1, a0_2, a1_1, a1_2,
                  wm0, am0, wm1, am1, ww0, aw0, ww1, aw1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic rec_t mk(bit v, bit we, bit ld, int rd, bit r1, int rs1, bit r2, int rs2);
        rec_t r;
        r.v = v; r.we = we; r.ld = ld; r.rd = rd;
        r.r1 = r1; r.rs1 = rs1; r.r2 = r2; r.rs2 = rs2;
        return r;
    endfunction

    function automatic rec_t nop();
        rec_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic bit reads(rec_t r, int x);
        return (r.r1 && r.rs1 == x) || (r.r2 && r.rs2 == x);
    endfunction

    function automatic bit load_use(rec_t r);
        if (!r.v) return 0;
        for (int j = 0; j < 2; j++)
            if (m_ex[j].v && m_ex[j].ld && m_ex[j].we && m_ex[j].rd != 0 && reads(r, m_ex[j].rd))
                return 1;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < 2; j++) begin
            m_ex[j] = nop(); m_lsu[j] = nop(); m_wb[j] = nop();
        end
        m_second = 0;
    endfunction

    function automatic void model_decide();
        bit ph, l0, l1, is0, is1;
        ph = cur[0].v && cur[1].v && cur[0].we && cur[0].rd != 0 &&
             (reads(cur[1], cur[0].rd) || (cur[1].we && cur[1].rd == cur[0].rd));
        l0 = load_use(cur[0]);
        l1 = load_use(cur[1]);
        exp_stall = 0; n_second = m_second; is0 = 0; is1 = 0;
        if (cur_ms) exp_stall = 1;
        else if (cur_fl) n_second = 0;
        else if (!m_second) begin
            if (l0 || (l1 && !ph)) exp_stall = 1;
            else if (ph) begin is0 = 1; exp_stall = 1; n_second = 1; end
            else begin is0 = 1; is1 = 1; end
        end else begin
            if (l1) exp_stall = 1;
            else begin is1 = 1; n_second = 0; end
        end
        n_ex[0] = (is0 && cur[0].v) ? cur[0] : nop();
        n_ex[1] = (is1 && cur[1].v) ? cur[1] : nop();
    endfunction

    function automatic logic [49:0] model_outs();
        bit w0, w1, v0, v1;
        w0 = m_lsu[0].v && m_lsu[0].we;
        w1 = m_lsu[1].v && m_lsu[1].we;
        v1 = m_wb[1].v && m_wb[1].we;
        v0 = m_wb[0].v && m_wb[0].we && !(w1 && m_lsu[1].rd == m_wb[0].rd);
        return {m_ex[0].v, m_ex[1].v, m_ex[0].r1, m_ex[0].r2, m_ex[1].r1, m_ex[1].r2,
                5'(m_ex[0].rs1), 5'(m_ex[0].rs2), 5'(m_ex[1].rs1), 5'(m_ex[1].rs2),
                w0, 5'(m_lsu[0].rd), w1, 5'(m_lsu[1].rd), v0, 5'(m_wb[0].rd), v1, 5'(m_wb[1].rd)};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(input rec_t l0, input rec_t l1, input bit ms, input bit fl);
        cur[0] = l0; cur[1] = l1; cur_ms = ms; cur_fl = fl;
        id_valid_0 = l0.v; id_we_0 = l0.we; id_load_0 = l0.ld; id_rd_0 = 5'(l0.rd);
        id_r1_0 = l0.r1; id_r2_0 = l0.r2; id_rs1_0 = 5'(l0.rs1); id_rs2_0 = 5'(l0.rs2);
        id_valid_1 = l1.v; id_we_1 = l1.we; id_load_1 = l1.ld; id_rd_1 = 5'(l1.rd);
        id_r1_1 = l1.r1; id_r2_1 = l1.r2; id_rs1_1 = 5'(l1.rs1); id_rs2_1 = 5'(l1.rs2);
        mem_stall = ms; flush = fl;
        #1;
        model_decide();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!cur_ms) begin
            m_wb = m_lsu; m_lsu = m_ex; m_ex = n_ex; m_second = n_second;
        end
        #1;
        exp_outs = model_outs();
    endtask

    task automatic drain();
        repeat (4) begin
            drive(nop(), nop(), 0, 0);
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0;
        drive(nop(), nop(), 0, 0);
        model_reset();
        exp_outs = model_outs();
        #2;
        n_tests++;
        if (act !== 50'd0) begin n_fail++; $display("[TB] FAIL reset_outs got %h want 0", act); end
        n_tests++;
        if (stall_id !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall got %b want 0", stall_id); end
        @(posedge clk); #1;
        rstn = 1'b1;
        drive(nop(), nop(), 0, 0);
        tick();
        n_tests++;
        if (act !== exp_outs) begin n_fail++; $display("[TB] FAIL reset_idle got %h want %h", act, exp_outs); end
    endtask

    task automatic test_independent();
        rec_t a, b;
        drain();
        a = mk(1, 1, 0, 1, 1, 2, 1, 3);
        b = mk(1, 1, 0, 4, 1, 5, 1, 6);
        for (int c = 0; c < 5; c++) begin
            drive(a, b, 0, 0);
            n_tests++;
            if (stall_id !== 1'b0) begin n_fail++; $display("[TB] FAIL indep_stall c%0d got %b want 0", c, stall_id); end
            tick();
            n_tests++;
            if (act !== exp_outs) begin n_fail++; $display("[TB] FAIL indep_outs c%0d got %h want %h", c, act, exp_outs); end
            if (c == 1) begin
                n_tests++;
                if ({wm0, am0, wm1, am1} !== {1'b1, 5'd1, 1'b1, 5'd4}) begin
                    n_fail++; $display("[TB] FAIL indep_lsu got %b/%0d %b/%0d want 1/1 1/4", wm0, am0, wm1, am1);
                end
            end
            if (c == 2) begin
                n_tests++;
                if ({ww0, aw0, ww1, aw1} !== {1'b1, 5'd1, 1'b1, 5'd4}) begin
                    n_fail++; $display("[TB] FAIL indep_wb got %b/%0d %b/%0d want 1/1 1/4", ww0, aw0, ww1, aw1);
                end
            end
        end
    endtask

    task automatic test_raw_pair();
        rec_t a, b;
        drain();
        a = mk(1, 1, 0, 7, 1, 1, 1, 2);
        b = mk(1, 1, 0, 8, 1, 7, 0, 0);
        drive(a, b, 0, 0);
        n_tests++;
        if (stall_id !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_stall0 got %b want 1", stall_id); end
        tick();
        n_tests++;
        if ({ex_valid_0, ex_valid_1} !== 2'b10 || act !== exp_outs) begin
            n_fail++; $display("[TB] FAIL raw_ex0 got %h want %h (ex_valid 10)", act, exp_outs);
        end
        drive(a, b, 0, 0);
        n_tests++;
        if (stall_id !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_stall1 got %b want 0", stall_id); end
        tick();
        n_tests++;
        if ({ex_valid_0, ex_valid_1, wm0, am0} !== {2'b01, 1'b1, 5'd7} || act !== exp_outs) begin
            n_fail++; $display("[TB] FAIL raw_ex1 got %h want %h (ex_valid 01, wm0 1, am0 7)", act, exp_outs);
        end
    endtask

    task automatic test_load_use();
        drain();
        drive(mk(1, 1, 1, 9, 1, 1, 0, 0), nop(), 0, 0);
        tick();
        drive(mk(1, 1, 0, 10, 1, 9, 0, 0), nop(), 0, 0);
        n_tests++;
        if (stall_id !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_stall got %b want 1", stall_id); end
        tick();
        n_tests++;
        if ({ex_valid_0, ex_valid_1} !== 2'b00 || act !== exp_outs) begin
            n_fail++; $display("[TB] FAIL lu_bubble got %h want %h", act, exp_outs);
        end
        drive(mk(1, 1, 0, 10, 1, 9, 0, 0), nop(), 0, 0);
        n_tests++;
        if (stall_id !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_release got %b want 0", stall_id); end
        tick();
        n_tests++;
        if ({ex_valid_0, ww0, aw0, wm0} !== {1'b1, 1'b1, 5'd9, 1'b0} || act !== exp_outs) begin
            n_fail++; $display("[TB] FAIL lu_consumer got %h want %h", act, exp_outs);
        end
    endtask

    task automatic test_wb_override();
        drain();
        drive(mk(1, 1, 0, 3, 1, 1, 0, 0), nop(), 0, 0);
        tick();
        drive(nop(), mk(1, 1, 0, 3, 1, 2, 0, 0), 0, 0);
        tick();
        drive(nop(), nop(), 0, 0);
        tick();
        n_tests++;
        if ({ww0, aw0, wm1, am1} !== {1'b0, 5'd3, 1'b1, 5'd3} || act !== exp_outs) begin
            n_fail++; $display("[TB] FAIL override got ww0=%b aw0=%0d wm1=%b am1=%0d (%h) want 0 3 1 3 (%h)",
                               ww0, aw0, wm1, am1, act, exp_outs);
        end
    endtask

    task automatic test_mem_stall_second();
        rec_t a, b;
        logic [49:0] snap;
        drain();
        a = mk(1, 1, 0, 7, 1, 1, 1, 2);
        b = mk(1, 1, 0, 8, 1, 7, 0, 0);
        drive(a, b, 0, 0);
        tick();
        snap = act;
        for (int c = 0; c < 3; c++) begin
            drive(a, b, 1, 0);
            n_tests++;
            if (stall_id !== 1'b1) begin n_fail++; $display("[TB] FAIL ms_stall c%0d got %b want 1", c, stall_id); end
            tick();
            n_tests++;
            if (act !== snap || act !== exp_outs) begin
                n_fail++; $display("[TB] FAIL ms_frozen c%0d got %h want %h", c, act, exp_outs);
            end
        end
        drive(a, b, 0, 0);
        n_tests++;
        if (stall_id !== 1'b0) begin n_fail++; $display("[TB] FAIL ms_release got %b want 0", stall_id); end
        tick();
        n_tests++;
        if ({ex_valid_0, ex_valid_1} !== 2'b01 || act !== exp_outs) begin
            n_fail++; $display("[TB] FAIL ms_second got %h want %h", act, exp_outs);
        end
        drive(a, b, 0, 0);
        n_tests++;
        if (stall_id !== 1'b1) begin n_fail++; $display("[TB] FAIL ms_back_pair got %b want 1", stall_id); end
        tick();
    endtask

    task automatic test_flush_reset();
        rec_t a, b;
        drain();
        a = mk(1, 1, 0, 5, 1, 1, 0, 0);
        b = mk(1, 1, 0, 6, 0, 0, 1, 5);
        drive(a, b, 0, 0);
        tick();
        drive(a, b, 0, 1);
        n_tests++;
        if (stall_id !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_stall got %b want 0", stall_id); end
        tick();
        n_tests++;
        if ({ex_valid_0, ex_valid_1} !== 2'b00 || act !== exp_outs) begin
            n_fail++; $display("[TB] FAIL flush_ex got %h want %h", act, exp_outs);
        end
        drive(a, b, 0, 0);
        n_tests++;
        if (stall_id !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_pair got %b want 1", stall_id); end
        tick();
        #2;
        rstn = 1'b0;
        model_reset();
        exp_outs = model_outs();
        #1;
        n_tests++;
        if (act !== 50'd0 || stall_id !== 1'b0) begin
            n_fail++; $display("[TB] FAIL async_reset got %h stall %b want 0 stall 0", act, stall_id);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        drive(a, b, 0, 0);
        n_tests++;
        if (stall_id !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_pair got %b want 1", stall_id); end
        tick();
        n_tests++;
        if ({ex_valid_0, ex_valid_1} !== 2'b10 || act !== exp_outs) begin
            n_fail++; $display("[TB] FAIL reset_issue got %h want %h", act, exp_outs);
        end
    endtask

    function automatic rec_t rnd_rec();
        return mk($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 7), $urandom_range(0, 9) < 6, $urandom_range(0, 7),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 7));
    endfunction

    task automatic test_random();
        rec_t a, b;
        bit ms, fl, held;
        drain();
        held = 0;
        a = nop(); b = nop();
        for (int c = 0; c < 500; c++) begin
            if (!held) begin a = rnd_rec(); b = rnd_rec(); end
            ms = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 19) == 0);
            drive(a, b, ms, fl);
            n_tests++;
            if (stall_id !== exp_stall) begin
                n_fail++; $display("[TB] FAIL rand_stall c%0d got %b want %b", c, stall_id, exp_stall);
            end
            held = exp_stall;
            tick();
            n_tests++;
            if (act !== exp_outs) begin
                n_fail++; $display("[TB] FAIL rand_outs c%0d got %h want %h", c, act, exp_outs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_pair();
        test_load_use();
        test_wb_override();
        test_mem_stall_second();
        test_flush_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_issue_hazard_ctrl.md
Name: dual_issue_hazard_ctrl

Overview:
- Pipeline control for the dual-issue ID→EX→LSU→WB pipeline; drives the EX-stage operand bypass network.
- Registers destination tags through EX/LSU/WB for both lanes and presents the LSU/WB write tags to the bypass network.
- Detects intra-pair RAW/WAW hazards and serialises the pair over two cycles; detects load-use hazards and stalls one cycle.
- Corrects the fixed bypass priority (lsu0 > wb0 > lsu1 > wb1) when a younger lsu1 write would lose to an older wb0 write.

Parameters:
- NREG, 32, architectural register count; address width is 5.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- id_valid_k_i  in  1  lane k (k=0,1) holds a valid decoded instruction; lane0 is older
- id_we_k_i  in  1  lane k writes rd
- id_rd_k_i  in  5  lane k destination
- id_load_k_i  in  1  lane k is a load
- id_r1_k_i, id_r2_k_i  in  1  lane k reads rs1 / rs2
- id_rs1_k_i, id_rs2_k_i  in  5  lane k source addresses
- mem_stall_i  in  1  LSU not ready; freeze whole pipeline
- flush_i  in  1  EX redirect; kill ID and EX contents
- stall_id_o  out  1  hold decode pair, fetch must not advance
- ex_valid_k_o  out  1  EX-stage lane k valid
- r0_1_o, r0_2_o, r1_1_o, r1_2_o  out  1  EX-stage read flags to bypass network
- a0_1_o, a0_2_o, a1_1_o, a1_2_o  out  5  EX-stage source addresses
- wm0_o, wm1_o, am0_o, am1_o  out  1/5  LSU-stage write flag / address per lane
- ww0_o, ww1_o, aw0_o, aw1_o  out  1/5  WB-stage write flag / address per lane

Behaviour:
- Reset: every register and output is 0; FSM is in PAIR; stall_id_o = 0.
- Each stage per lane holds {valid, we, load, rd}; ID→EX additionally captures r/a source fields. The write flag at a stage is valid & we.
- wm*/am* and ww*/aw* come straight from the LSU/WB registers. Exception: ww0_o = ww0_q & ~(wm1_q & am1_q == aw0_q), so the younger lsu1 value wins over the older wb0 value.
- Intra-pair hazard: valid0 & valid1 & we0 & rd0≠0 & (rd0 matches rs1/rs2 of lane1 with its r flag set, or we1 & rd1==rd0).
- Load-use, per lane: some EX lane has valid & load & we & rd≠0 & rd equal to a read source of the ID lane.
- FSM PAIR:
  - load-use on lane0, or on lane1 with no pair hazard → bubble both lanes into EX, stall_id_o=1, stay in PAIR.
  - pair hazard → issue lane0 only (lane1 bubble), stall_id_o=1, go to SECOND.
  - otherwise issue both lanes, stall_id_o=0.
- FSM SECOND:
  - lane0 slot is a bubble.
  - load-use on lane1 → bubble, stall_id_o=1, stay in SECOND.
  - otherwise issue lane1, stall_id_o=0, go to PAIR.
- An invalid ID lane issues as a bubble and never causes a stall.
- mem_stall_i has the highest priority: all stage registers and the FSM hold, and stall_id_o=1.
- flush_i (when mem_stall_i=0): EX registers load bubbles, FSM goes to PAIR, stall_id_o=0. LSU and WB still advance normally, so the EX contents move to LSU that cycle.
- Latency: EX outputs appear 1 cycle after an issue decision. A producer reaches LSU 2 cycles after issue and WB 3 cycles after issue.

Decomposition:
- Shared core package holds: REG_AW=5, the {valid, we, load, rd} stage-tag struct, and the FSM state enum (PAIR, SECOND).
- One natural sub-module: hazard_match, a combinational compare of one ID lane's sources against a tag list, instantiated per lane.
- Stage registers and the FSM stay in the top module.

Test Plan:
- Independent pair (x1←x2+x3, x4←x5+x6) → both lanes issue every cycle, stall_id_o=0. Tags reach wm at +2 and ww at +3 with am0=1, am1=4.
- Pair with RAW (lane0 writes x7, lane1 reads x7) → cycle0: ex_valid=10, stall=1. Cycle1: ex_valid=01, stall=0. When lane1 is in EX, wm0=1, am0=7.
- Load x9 in EX, ID lane0 reads x9 → one bubble cycle with stall=1. The consumer enters EX with ww0=1, aw0=9 and wm0=0.
- lsu1 writing x3 while wb0 also writes x3 → ww0_o=0, wm1_o=1, am1_o=3.
- mem_stall_i held 3 cycles mid-SECOND → all outputs frozen; after release, lane1 issues once and the FSM returns to PAIR.
- flush_i during SECOND, then rstn_i pulsed low mid-run → ex_valid=00, FSM in PAIR. Reset immediately zeroes every output, with no clock edge required.
